// File: rtl/note_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// note_sequencer_pkg: state codes, song-word field layout, word decoder. Rev 1.0
// ----------------------------------------------------------------------------
package note_sequencer_pkg;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH = 3'd1;
  localparam logic [STATE_W-1:0] ST_LOAD  = 3'd2;
  localparam logic [STATE_W-1:0] ST_PLAY  = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

  localparam int END_BIT = 27;
  localparam int NOTE_HI = 26;
  localparam int NOTE_LO = 21;
  localparam int DUR_HI  = 20;
  localparam int DUR_LO  = 15;
  localparam int AMP_HI  = 14;
  localparam int AMP_LO  = 12;
  localparam int ATK_HI  = 11;
  localparam int ATK_LO  = 6;
  localparam int DEC_HI  = 5;
  localparam int DEC_LO  = 0;

  localparam logic [5:0] NOTE_REST = 6'd0;

  typedef struct packed {
    logic [5:0] note;
    logic [5:0] dur;
    logic [2:0] amp;
    logic [5:0] atk;
    logic [5:0] dec;
  } note_fields_t;

  function automatic note_fields_t unpack_word(input logic [END_BIT:0] word);
    note_fields_t f;
    f.note = word[NOTE_HI:NOTE_LO];
    f.dur  = word[DUR_HI:DUR_LO];
    f.amp  = word[AMP_HI:AMP_LO];
    f.atk  = word[ATK_HI:ATK_LO];
    f.dec  = word[DEC_HI:DEC_LO];
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// note_sequencer: walks the song ROM and holds each decoded note for its beats. Rev 1.0
// ----------------------------------------------------------------------------
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 28
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              play_i,
  input  logic              beat_i,
  output logic [ADDR_W-1:0] song_addr_o,
  input  logic [DATA_W-1:0] song_data_i,
  output logic [5:0]        note_o,
  output logic [5:0]        duration_o,
  output logic [2:0]        amplitude_o,
  output logic [5:0]        attack_o,
  output logic [5:0]        decay_o,
  output logic              new_note_o,
  output logic              song_done_o,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [STATE_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  note_fields_t       fields_q, fields_d;
  logic [5:0]         cnt_q, cnt_d;
  logic               new_note_q, new_note_d;
  logic               song_done_q, song_done_d;
  logic               busy_q, busy_d;

  note_fields_t w_word;
  logic         w_word_end;
  logic [5:0]   w_dur_m1;

  assign w_word     = unpack_word(song_data_i[END_BIT:0]);
  assign w_word_end = song_data_i[END_BIT];
  // Skipped words never reach PLAY, so dur is at least 1 here and cannot underflow.
  assign w_dur_m1   = fields_q.dur - 6'd1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      fields_q    <= '0;
      cnt_q       <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      fields_q    <= fields_d;
      cnt_q       <= cnt_d;
      new_note_q  <= new_note_d;
      song_done_q <= song_done_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    fields_d = fields_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (play_i) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_word_end) begin
          addr_d  = '0;
          state_d = ST_DONE;
        end else if (w_word.dur == 6'd0) begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = ST_FETCH;
        end else begin
          fields_d = w_word;
          cnt_d    = '0;
          state_d  = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // Pause (play low) freezes the count and ignores beats.
        if (play_i && beat_i) begin
          if (cnt_q == w_dur_m1) begin
            addr_d  = addr_q + ADDR_ONE;
            state_d = ST_FETCH;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      ST_DONE: begin
        addr_d = '0;
        if (!play_i) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    new_note_d  = (state_q == ST_LOAD) && !w_word_end && (w_word.dur != 6'd0) &&
                  (w_word.note != NOTE_REST);
    song_done_d = (state_q == ST_LOAD) && w_word_end;
    busy_d      = (state_d == ST_FETCH) || (state_d == ST_LOAD) || (state_d == ST_PLAY);
  end

  assign song_addr_o = addr_q;
  assign note_o      = fields_q.note;
  assign duration_o  = fields_q.dur;
  assign amplitude_o = fields_q.amp;
  assign attack_o    = fields_q.atk;
  assign decay_o     = fields_q.dec;
  assign new_note_o  = new_note_q;
  assign song_done_o = song_done_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Upstream of the dynamics stage in the music player.
- Walks a song ROM one note word at a time and decodes each word into note, duration, amplitude, attack and decay.
- Pulses new_note when a sounding note starts, then holds it for exactly `duration` beats before fetching the next word.
- Handles rests, play/pause, zero-duration words, end-of-song and address wrap.

Parameters:
- ADDR_W, 7, song ROM address width.
- DATA_W, 28, song word width; fixed field layout is given under Behaviour.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- play  in  1  level; 1 = run, 0 = pause
- beat  in  1  one-cycle 1/48 s tick
- song_addr  out  ADDR_W  ROM address, registered
- song_data  in  DATA_W  ROM data, valid 1 cycle after song_addr changes
- note  out  6  note code, 0 = rest
- duration  out  6  note length in beats
- amplitude  out  3  note amplitude
- attack  out  6  attack length in beats
- decay  out  6  decay length in beats
- new_note  out  1  one-cycle pulse at start of a sounding note
- song_done  out  1  one-cycle pulse at end of song
- busy  out  1  high in FETCH, LOAD and PLAY

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While reset is high:
  - state = IDLE, song_addr = 0, beat counter = 0.
  - All field outputs = 0; new_note, song_done, busy = 0.
  - Reset mid-note aborts the note immediately.
- Word layout:
  - [27] end flag, [26:21] note, [20:15] duration, [14:12] amplitude, [11:6] attack, [5:0] decay.
- States: IDLE, FETCH, LOAD, PLAY, DONE.
- IDLE: play=1 -> FETCH next cycle; otherwise stay.
- FETCH: one wait cycle for ROM latency -> LOAD.
- LOAD: evaluate song_data; exactly one of the following, in priority order:
  - End flag = 1 -> DONE. song_done pulses in the cycle after LOAD; no field update.
  - Duration field = 0 -> word skipped. Fields unchanged, no pulse, song_addr+1, -> FETCH.
  - Otherwise: register all fields, clear beat counter -> PLAY. new_note = 1 for the first PLAY cycle only, and only if note != 0. A rest produces no pulse but still updates all fields, so note output = 0.
- PLAY:
  - Beat counter increments on each beat while play=1.
  - On a beat with counter == duration-1: song_addr+1 -> FETCH. The note occupies exactly `duration` beats.
- Pause: play=0 in PLAY freezes the counter, ignores beats, and holds every output. play=0 in FETCH or LOAD does not stop that fetch; the next PLAY is frozen.
- DONE: song_addr = 0. Stay in DONE until play=0, then -> IDLE. No automatic replay while play is held high.
- Beats arriving in IDLE, FETCH, LOAD or DONE are ignored. The fetch gap is 2 cycles, which is far below beat spacing.
- Address wrap: incrementing from 2^ADDR_W-1 wraps to 0 without asserting song_done.
- Field outputs change only in the LOAD-to-PLAY transition or on reset. They stay stable throughout a note, as the dynamics stage requires.
- Width rules:
  - Beat counter is 6 bits, unsigned.
  - Compare against duration-1 in 6 bits; duration >= 1 is guaranteed by the skip rule.
- Outputs are registered with no combinational path from inputs, except song_addr, which is a register.

Decomposition:
- Shared package:
  - State encoding constants.
  - Word-field bit positions: END_BIT, NOTE_HI/LO, DUR_HI/LO, AMP_HI/LO, ATK_HI/LO, DEC_HI/LO.
  - NOTE_REST = 0.
- Build the FSM with dffr/dffre flops; no sub-module is needed.

Test Plan:
- ROM[0]={end=0, note=12, dur=3, amp=5, atk=1, dec=1}, play=1 -> new_note pulses once; note=12, duration=3, amplitude=5; exactly 3 beats later song_addr=1.
- ROM[1] rest (note=0, dur=2) -> no new_note; note=0 held; song_addr=2 after 2 beats.
- ROM[2] dur=0, ROM[3] note=20, dur=1 -> word 2 skipped with no pulse; new_note for note=20 within 4 cycles of leaving word 1.
- ROM[4] end=1 -> song_done one-cycle pulse; song_addr=0; busy=0. Holding play=1 causes no refetch; play 0->1 restarts at note 12.
- Pause: play=0 after 1 of 3 beats, apply 5 beats, then play=1 -> note ends after 2 further beats; outputs unchanged during the pause.
- Assert reset mid-PLAY, asynchronously between edges -> outputs 0 and song_addr=0 immediately; wrap case with ADDR_W=2 and no end flag -> address sequence 3 then 0, no song_done.
